// File: rtl/tx_frame_rx.sv
// tx_frame_rx: serial frame receiver for the hit-counting core's TX line.
// Frame: start(0), NOM[3:0] LSB first, BIT[1:0] LSB first, even parity P, stop(1).
// Each bit lasts BIT_CYCLES clocks. Good frames update NOM_Q/BIT_Q, pulse VLD
// and advance the LE counter. Bad parity pulses PERR. A missing stop bit pulses
// FERR and parks the FSM in BREAK until the line has been idle for one bit time.
// Optional build macro: TX_FRAME_RX_FILTER_EN
//   Each sample becomes a majority vote over three consecutive rx_s values.
//   The vote needs the value one cycle after the sample point, so every
//   decision, and therefore every strobe, lands one cycle later.
module tx_frame_rx #(
  parameter int BIT_CYCLES = 16,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             rx,
  output logic [3:0]       NOM_Q,
  output logic [1:0]       BIT_Q,
  output logic             VLD,
  output logic             PERR,
  output logic             FERR,
  output logic [CNT_W-1:0] LE,
  output logic             BUSY
);

  localparam int CW = $clog2(BIT_CYCLES);
`ifdef TX_FRAME_RX_FILTER_EN
  // The vote completes one cycle after the nominal sample point.
  localparam int START_PT = BIT_CYCLES / 2;
`else
  localparam int START_PT = BIT_CYCLES / 2 - 1;
`endif
  localparam logic [CW-1:0] START_CNT = CW'(START_PT);
  localparam logic [CW-1:0] LAST_CNT  = CW'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [2:0]       idx_reg, idx_next;
  logic [5:0]       shift_reg, shift_next;
  logic             par_reg, par_next;
  logic [3:0]       nom_reg, nom_next;
  logic [1:0]       bit_reg, bit_next;
  logic             vld_reg, vld_next;
  logic             perr_reg, perr_next;
  logic             ferr_reg, ferr_next;
  logic [CNT_W-1:0] le_reg, le_next;
  logic             sync1_reg, rx_s;
  logic             samp_bit;
  logic             sample_now;

  // Two-flop synchronizer; both flops reset to the idle line level.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1_reg <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      sync1_reg <= rx;
      rx_s      <= sync1_reg;
    end
  end

`ifdef TX_FRAME_RX_FILTER_EN
  logic rx_d1_reg, rx_d2_reg;

  // History of rx_s used for the majority vote (sample point and the cycle before).
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rx_d1_reg <= 1'b1;
      rx_d2_reg <= 1'b1;
    end else begin
      rx_d1_reg <= rx_s;
      rx_d2_reg <= rx_d1_reg;
    end
  end

  assign samp_bit = (rx_s & rx_d1_reg) | (rx_s & rx_d2_reg) | (rx_d1_reg & rx_d2_reg);
`else
  assign samp_bit = rx_s;
`endif

  // Half a bit time into the start bit, then once per bit time after that.
  assign sample_now = (state_reg == START) ? (cnt_reg == START_CNT) : (cnt_reg == LAST_CNT);

  // State and datapath registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      nom_reg   <= '0;
      bit_reg   <= '0;
      vld_reg   <= 1'b0;
      perr_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
      le_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      nom_reg   <= nom_next;
      bit_reg   <= bit_next;
      vld_reg   <= vld_next;
      perr_reg  <= perr_next;
      ferr_reg  <= ferr_next;
      le_reg    <= le_next;
    end
  end

  // Next-state, bit-time counter and frame decoding.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CW'(1);
    idx_next   = idx_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    nom_next   = nom_reg;
    bit_next   = bit_reg;
    vld_next   = 1'b0;
    perr_next  = 1'b0;
    ferr_next  = 1'b0;
    le_next    = le_reg;

    unique case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (!rx_s) state_next = START;
      end
      START: begin
        if (sample_now) begin
          cnt_next = '0;
          if (samp_bit) begin
            state_next = IDLE;
          end else begin
            state_next = DATA;
            idx_next   = '0;
          end
        end
      end
      DATA: begin
        if (sample_now) begin
          cnt_next   = '0;
          shift_next = {samp_bit, shift_reg[5:1]};
          idx_next   = idx_reg + 3'd1;
          if (idx_reg == 3'd5) state_next = PARITY;
        end
      end
      PARITY: begin
        if (sample_now) begin
          cnt_next   = '0;
          par_next   = samp_bit;
          state_next = STOP;
        end
      end
      STOP: begin
        if (sample_now) begin
          cnt_next = '0;
          if (!samp_bit) begin
            ferr_next  = 1'b1;
            state_next = BREAK;
          end else if (^{shift_reg, par_reg} == 1'b0) begin
            nom_next   = shift_reg[3:0];
            bit_next   = shift_reg[5:4];
            vld_next   = 1'b1;
            le_next    = le_reg + CNT_W'(1);
            state_next = IDLE;
          end else begin
            perr_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      BREAK: begin
        // Need BIT_CYCLES consecutive high samples before accepting a new start.
        if (!rx_s) begin
          cnt_next = '0;
        end else if (cnt_reg == LAST_CNT) begin
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign NOM_Q = nom_reg;
  assign BIT_Q = bit_reg;
  assign VLD   = vld_reg;
  assign PERR  = perr_reg;
  assign FERR  = ferr_reg;
  assign LE    = le_reg;
  assign BUSY  = (state_reg != IDLE);

endmodule
